// File: rtl/conv_ctrl_if.sv
// Bundles the conv_ctrl run handshake and its weight-memory, feature-memory,
// Conv and output-memory connections; master is the sequencer side.
interface conv_ctrl_if #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
);
    logic                          start;
    logic [ADDR_BITS-1:0]          len;
    logic                          busy;
    logic                          done;
    logic                          err;
    logic                          w_ren;
    logic [1:0]                    w_addr;
    logic signed [DATA_BITS-1:0]   w_rdata;
    logic                          if_ren;
    logic [ADDR_BITS-1:0]          if_addr;
    logic signed [DATA_BITS-1:0]   if_rdata;
    logic                          conv_clear;
    logic                          conv_w_w;
    logic signed [DATA_BITS-1:0]   conv_w_in;
    logic                          conv_if_w;
    logic signed [DATA_BITS-1:0]   conv_if_in;
    logic signed [2*DATA_BITS+1:0] conv_result;
    logic                          out_wen;
    logic [ADDR_BITS-1:0]          out_addr;
    logic signed [2*DATA_BITS+1:0] out_data;

    modport master (
        input  start, len, w_rdata, if_rdata, conv_result,
        output busy, done, err, w_ren, w_addr, if_ren, if_addr,
               conv_clear, conv_w_w, conv_w_in, conv_if_w, conv_if_in,
               out_wen, out_addr, out_data
    );

    modport slave (
        output start, len, w_rdata, if_rdata, conv_result,
        input  busy, done, err, w_ren, w_addr, if_ren, if_addr,
               conv_clear, conv_w_w, conv_w_in, conv_if_w, conv_if_in,
               out_wen, out_addr, out_data
    );
endinterface

// File: rtl/conv_ctrl.sv
// Sequencer for the 3-tap Conv MAC: clear, load 3 weights, stream LEN features,
// write LEN-2 results, pulse done. Define CONV_CTRL_RELU_EN to clamp negative results to 0.
module conv_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic            clk,
    input  logic            rst,
    conv_ctrl_if.master     bus
);
    localparam int RES_BITS = 2*DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LDW, S_FEED, S_DRAIN, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] len_q, len_d;
    logic                 short_q, short_d;
    logic                 w_w_q, w_w_d;
    logic                 if_w_q, if_w_d;
    logic [ADDR_BITS-1:0] feed_idx_q, feed_idx_d;
    logic                 out_wen_q, out_wen_d;
    logic [ADDR_BITS-1:0] out_addr_q, out_addr_d;

    function automatic logic signed [RES_BITS-1:0] relu(input logic signed [RES_BITS-1:0] v);
`ifdef CONV_CTRL_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        short_d = short_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d = bus.len;
                    cnt_d = '0;
                    // Too short for even one 3-tap window: report without touching memories.
                    if (bus.len < ADDR_BITS'(3)) begin
                        short_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        short_d = 1'b0;
                        state_d = S_CLR;
                    end
                end
            end
            S_CLR: begin
                cnt_d   = '0;
                state_d = S_LDW;
            end
            S_LDW: begin
                if (cnt_q == ADDR_BITS'(2)) begin
                    cnt_d   = '0;
                    state_d = S_FEED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FEED: begin
                if (cnt_q == len_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Two cycles cover the memory read and Conv shift of the last feature.
            S_DRAIN: begin
                if (cnt_q == ADDR_BITS'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                short_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-to-Conv and Conv-to-write delay lines; a result exists once x[k+2] is in.
    always_comb begin
        w_w_d      = (state_q == S_LDW);
        if_w_d     = (state_q == S_FEED);
        feed_idx_d = if_w_d ? cnt_q : '0;
        out_wen_d  = if_w_q && (feed_idx_q >= ADDR_BITS'(2));
        out_addr_d = out_wen_d ? (feed_idx_q - ADDR_BITS'(2)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            short_q    <= 1'b0;
            w_w_q      <= 1'b0;
            if_w_q     <= 1'b0;
            feed_idx_q <= '0;
            out_wen_q  <= 1'b0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            short_q    <= short_d;
            w_w_q      <= w_w_d;
            if_w_q     <= if_w_d;
            feed_idx_q <= feed_idx_d;
            out_wen_q  <= out_wen_d;
            out_addr_q <= out_addr_d;
        end
    end

    // Data outputs are gated by their strobes so reset forces every output to 0.
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_DONE) && short_q;
    assign bus.conv_clear = (state_q == S_CLR);
    assign bus.w_ren      = (state_q == S_LDW);
    assign bus.w_addr     = (state_q == S_LDW) ? cnt_q[1:0] : 2'b00;
    assign bus.if_ren     = (state_q == S_FEED);
    assign bus.if_addr    = (state_q == S_FEED) ? cnt_q : '0;
    assign bus.conv_w_w   = w_w_q;
    assign bus.conv_w_in  = w_w_q ? bus.w_rdata : '0;
    assign bus.conv_if_w  = if_w_q;
    assign bus.conv_if_in = if_w_q ? bus.if_rdata : '0;
    assign bus.out_wen    = out_wen_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_wen_q ? relu(bus.conv_result) : '0;
endmodule
